// File: rtl/odd_width_pkt_arbiter.sv
// Packet-locked round-robin arbiter feeding a narrow-to-wide width converter.
// Define ODD_ARB_STAT_EN to add per-packet converter word-count statistics.
module odd_width_pkt_arbiter #(
  parameter int NUM   = 4,
  parameter int ISIZE = 12,
  parameter int OSIZE = 16,
  localparam int IW   = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM*ISIZE-1:0] s_data,
  input  logic [NUM-1:0]       s_vld,
  input  logic [NUM-1:0]       s_last,
  output logic [NUM-1:0]       s_ready,
  output logic [ISIZE-1:0]     m_data,
  output logic                 m_vld,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic [IW-1:0]        gnt_id,
  output logic                 busy
`ifdef ODD_ARB_STAT_EN
  ,
  output logic                 stat_vld,
  output logic [IW-1:0]        stat_id,
  output logic [15:0]          stat_words
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state;
  logic [IW-1:0]    last_gnt;
  logic [IW-1:0]    pick;
  logic [IW-1:0]    rr_cand;
  logic [ISIZE-1:0] src_data [NUM];
  logic             accept;

  for (genvar i = 0; i < NUM; i++) begin : g_unpack
    assign src_data[i] = s_data[i*ISIZE +: ISIZE];
  end

  // Scan from the farthest offset down so the nearest requester after last_gnt wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    pick    = last_gnt;
    rr_cand = last_gnt;
    for (int k = NUM; k >= 1; k--) begin
      rr_cand = IW'((int'(last_gnt) + k) % NUM);
      if (s_vld[rr_cand]) pick = rr_cand;
    end
  end

  assign busy   = (state == BUSY);
  assign m_vld  = busy & s_vld[gnt_id];
  assign m_last = busy & s_last[gnt_id];
  assign m_data = busy ? src_data[gnt_id] : '0;
  assign accept = m_vld & m_ready;

  always_comb begin
    s_ready = '0;
    if (busy) s_ready[gnt_id] = m_ready;
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      gnt_id   <= '0;
      last_gnt <= IW'(NUM - 1);
    end else begin
      case (state)
        IDLE: if (|s_vld) begin
          gnt_id <= pick;
          state  <= BUSY;
        end
        BUSY: if (accept && m_last) begin
          last_gnt <= gnt_id;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef ODD_ARB_STAT_EN
  localparam int AW = $clog2(2 * OSIZE);
  localparam int SW = AW + 1;

  logic [AW-1:0] acc, acc_nxt;
  logic [SW-1:0] acc_sum;
  logic [15:0]   wcnt, wcnt_nxt, words_fin;

  // Bits left over after emitting whole OSIZE words; a non-empty remainder costs one more word.
  always_comb begin
    acc_sum  = SW'(acc) + SW'(ISIZE);
    acc_nxt  = AW'(acc_sum);
    wcnt_nxt = wcnt;
    if (acc_sum >= SW'(OSIZE)) begin
      acc_nxt = AW'(acc_sum - SW'(OSIZE));
      if (wcnt != 16'hFFFF) wcnt_nxt = wcnt + 16'd1;
    end
    words_fin = wcnt_nxt;
    if (acc_nxt != '0 && wcnt_nxt != 16'hFFFF) words_fin = wcnt_nxt + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      acc        <= '0;
      wcnt       <= '0;
      stat_vld   <= 1'b0;
      stat_id    <= '0;
      stat_words <= '0;
    end else begin
      stat_vld <= 1'b0;
      if (state == IDLE && |s_vld) begin
        acc  <= '0;
        wcnt <= '0;
      end else if (accept) begin
        acc  <= acc_nxt;
        wcnt <= wcnt_nxt;
        if (m_last) begin
          stat_vld   <= 1'b1;
          stat_id    <= gnt_id;
          stat_words <= words_fin;
        end
      end
    end
  end
`endif

endmodule
